flag_context_stack: RTL and testbench

FLAG_CONTEXT_STACK -- requirements
Module: flag_context_stack

---
 rtl/flag_context_stack.sv | 188 ++++++++++++++++++
 tb/tb_flag_context_stack.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_context_stack.sv
// flag_context_stack
//
// Saves and restores processor status-flag contexts around exceptions. It
// also evaluates ARM-style condition codes against the live flags.
//
// The live flags {N,Z,C,V,M} are pushed on exception entry and popped on
// exception return. A push and a pop in the same cycle swap the top entry
// with the live flags. A push onto a full stack is dropped, and a pop from
// an empty stack is ignored. Either of these sets a sticky error flag that
// only reset clears.
//
// Ports
//   clock, reset          : sole clock; synchronous active-high reset
//   negative_flag .. mode_flag : live status flags N, Z, C, V, M
//   push, pop             : save / restore a flag context
//   cond_valid, cond_code : request a condition evaluation this cycle
//   cond_ready, cond_true : registered condition result, valid one cycle later
//   restore_valid         : single-cycle pulse, restore_flags holds the popped context
//   restore_flags         : popped context {N,Z,C,V,M}
//   depth                 : number of occupied entries, 0..DEPTH
//   stack_empty/full      : depth == 0 / depth == DEPTH
//   error                 : sticky overflow/underflow indicator
module flag_context_stack #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       negative_flag,
    input  logic       zero_flag,
    input  logic       carry_flag,
    input  logic       overflow_flag,
    input  logic       mode_flag,
    input  logic       push,
    input  logic       pop,
    input  logic       cond_valid,
    input  logic [3:0] cond_code,
    output logic       cond_ready,
    output logic       cond_true,
    output logic       restore_valid,
    output logic [4:0] restore_flags,
    output logic [3:0] depth,
    output logic       stack_empty,
    output logic       stack_full,
    output logic       error
);

    localparam int         AW         = $clog2(DEPTH);
    localparam logic [3:0] FULL_LEVEL = 4'(DEPTH);

    // The declaration initialisers give the same state at power-up that
    // reset produces.
    logic [3:0] depth_q         = 4'd0;
    logic [4:0] restore_flags_q = 5'd0;
    logic       restore_valid_q = 1'b0;
    logic       error_q         = 1'b0;
    logic       cond_ready_q    = 1'b0;
    logic       cond_true_q     = 1'b0;
    logic [4:0] stack_q [DEPTH] = '{default: 5'd0};

    logic [3:0] depth_d;
    logic [4:0] restore_flags_d;
    logic       restore_valid_d;
    logic       error_d;
    logic       cond_ready_d;
    logic       cond_true_d;
    logic [4:0] stack_d [DEPTH];

    logic [4:0]    live_flags;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          is_empty;
    logic          is_full;
    logic          cond_result;

    assign live_flags = {negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag};

    // wr_idx is the first free slot and rd_idx is the top entry. Both can
    // wrap at the empty/full boundary, but neither is used in those cases.
    assign wr_idx   = depth_q[AW-1:0];
    assign rd_idx   = wr_idx - AW'(1);
    assign is_empty = (depth_q == 4'd0);
    assign is_full  = (depth_q == FULL_LEVEL);

    // Condition-code decode against the live flags present this cycle.
    always_comb begin
        cond_result = 1'b0;
        unique case (cond_code)
            4'd0:  cond_result = zero_flag;
            4'd1:  cond_result = !zero_flag;
            4'd2:  cond_result = carry_flag;
            4'd3:  cond_result = !carry_flag;
            4'd4:  cond_result = negative_flag;
            4'd5:  cond_result = !negative_flag;
            4'd6:  cond_result = overflow_flag;
            4'd7:  cond_result = !overflow_flag;
            4'd8:  cond_result = carry_flag && !zero_flag;
            4'd9:  cond_result = !carry_flag || zero_flag;
            4'd10: cond_result = (negative_flag == overflow_flag);
            4'd11: cond_result = (negative_flag != overflow_flag);
            4'd12: cond_result = !zero_flag && (negative_flag == overflow_flag);
            4'd13: cond_result = zero_flag || (negative_flag != overflow_flag);
            4'd14: cond_result = 1'b1;
            4'd15: cond_result = 1'b0;
            default: cond_result = 1'b0;
        endcase
    end

    // Next-state logic for the stack and the condition result.
    // Condition evaluation is independent of push/pop. cond_true only
    // changes when an evaluation is requested.
    always_comb begin
        depth_d         = depth_q;
        stack_d         = stack_q;
        restore_flags_d = restore_flags_q;
        restore_valid_d = 1'b0;
        error_d         = error_q;
        cond_ready_d    = cond_valid;
        cond_true_d     = cond_valid ? cond_result : cond_true_q;

        unique case ({push, pop})
            2'b10: begin
                if (is_full) begin
                    error_d = 1'b1;
                end else begin
                    stack_d[wr_idx] = live_flags;
                    depth_d         = depth_q + 4'd1;
                end
            end
            2'b01: begin
                if (is_empty) begin
                    error_d = 1'b1;
                end else begin
                    restore_flags_d = stack_q[rd_idx];
                    restore_valid_d = 1'b1;
                    depth_d         = depth_q - 4'd1;
                end
            end
            2'b11: begin
                // Swap the top entry with the live flags. On an empty stack
                // there is nothing to restore, so the pop is an underflow
                // and only the push happens.
                if (is_empty) begin
                    stack_d[wr_idx] = live_flags;
                    depth_d         = 4'd1;
                    error_d         = 1'b1;
                end else begin
                    restore_flags_d = stack_q[rd_idx];
                    restore_valid_d = 1'b1;
                    stack_d[rd_idx] = live_flags;
                end
            end
            default: begin
            end
        endcase
    end

    // State register. Reset discards all saved contexts by clearing depth.
    // The stack storage itself is left alone because entries above depth
    // are never observed.
    always_ff @(posedge clock) begin
        if (reset) begin
            depth_q         <= 4'd0;
            restore_flags_q <= 5'd0;
            restore_valid_q <= 1'b0;
            error_q         <= 1'b0;
            cond_ready_q    <= 1'b0;
            cond_true_q     <= 1'b0;
        end else begin
            depth_q         <= depth_d;
            restore_flags_q <= restore_flags_d;
            restore_valid_q <= restore_valid_d;
            error_q         <= error_d;
            cond_ready_q    <= cond_ready_d;
            cond_true_q     <= cond_true_d;
            stack_q         <= stack_d;
        end
    end

    assign cond_ready    = cond_ready_q;
    assign cond_true     = cond_true_q;
    assign restore_valid = restore_valid_q;
    assign restore_flags = restore_flags_q;
    assign depth         = depth_q;
    assign stack_empty   = is_empty;
    assign stack_full    = is_full;
    assign error         = error_q;

endmodule

// File: tb/tb_flag_context_stack.sv
// Testbench for flag_context_stack (DEPTH = 4).
// A behavioural model computes the expected outputs for each driven cycle.
// Those values are queued and then compared after the following clock edge.
module tb_flag_context_stack;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       negative_flag = 1'b0;
    logic       zero_flag = 1'b0;
    logic       carry_flag = 1'b0;
    logic       overflow_flag = 1'b0;
    logic       mode_flag = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       cond_valid = 1'b0;
    logic [3:0] cond_code = 4'd0;
    logic       cond_ready;
    logic       cond_true;
    logic       restore_valid;
    logic [4:0] restore_flags;
    logic [3:0] depth;
    logic       stack_empty;
    logic       stack_full;
    logic       error;

    flag_context_stack #(.DEPTH(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .negative_flag (negative_flag),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag),
        .mode_flag     (mode_flag),
        .push          (push),
        .pop           (pop),
        .cond_valid    (cond_valid),
        .cond_code     (cond_code),
        .cond_ready    (cond_ready),
        .cond_true     (cond_true),
        .restore_valid (restore_valid),
        .restore_flags (restore_flags),
        .depth         (depth),
        .stack_empty   (stack_empty),
        .stack_full    (stack_full),
        .error         (error)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    typedef struct packed {
        logic       cr;
        logic       ct;
        logic       rv;
        logic [4:0] rf;
        logic [3:0] dp;
        logic       emp;
        logic       full;
        logic       err;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    logic [4:0] m_stack[$];
    logic       m_cr  = 1'b0;
    logic       m_ct  = 1'b0;
    logic       m_rv  = 1'b0;
    logic [4:0] m_rf  = 5'd0;
    logic       m_err = 1'b0;

    // Condition codes grouped in pairs: the odd code inverts the even one.
    function automatic logic cond_model(input logic [3:0] code, input logic [4:0] f);
        logic n, z, c, v, base;
        n = f[4]; z = f[3]; c = f[2]; v = f[1];
        case (code[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = ~(n ^ v);
            3'd6: base = ~z & ~(n ^ v);
            default: base = 1'b1;
        endcase
        return base ^ code[0];
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.cr   = m_cr;
        e.ct   = m_ct;
        e.rv   = m_rv;
        e.rf   = m_rf;
        e.dp   = 4'(m_stack.size());
        e.emp  = (m_stack.size() == 0);
        e.full = (m_stack.size() == 4);
        e.err  = m_err;
        return e;
    endfunction

    task automatic cmp(input string name, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $display("[TB] FAIL %s observed=%h expected=%h", name, obs, expv);
            $error("[TB] %s observed=%h expected=%h", name, obs, expv);
        end
    endtask

    // Pop the oldest expectation and compare it with every DUT output.
    task automatic checkOutput();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            cmp({t, ".cond_ready"},    8'(cond_ready),    8'(e.cr));
            cmp({t, ".cond_true"},     8'(cond_true),     8'(e.ct));
            cmp({t, ".restore_valid"}, 8'(restore_valid), 8'(e.rv));
            cmp({t, ".restore_flags"}, 8'(restore_flags), 8'(e.rf));
            cmp({t, ".depth"},         8'(depth),         8'(e.dp));
            cmp({t, ".stack_empty"},   8'(stack_empty),   8'(e.emp));
            cmp({t, ".stack_full"},    8'(stack_full),    8'(e.full));
            cmp({t, ".error"},         8'(error),         8'(e.err));
        end
    endtask

    // Drive one cycle of stimulus, advance the model, queue the expected
    // result, then check it just after the clock edge.
    task automatic applyStimulus(input string tag, input logic rst, input logic ps,
                                 input logic pp, input logic cv, input logic [3:0] code,
                                 input logic [4:0] flags);
        reset         = rst;
        push          = ps;
        pop           = pp;
        cond_valid    = cv;
        cond_code     = code;
        negative_flag = flags[4];
        zero_flag     = flags[3];
        carry_flag    = flags[2];
        overflow_flag = flags[1];
        mode_flag     = flags[0];

        if (rst) begin
            m_cr = 1'b0; m_ct = 1'b0; m_rv = 1'b0; m_rf = 5'd0; m_err = 1'b0;
            m_stack.delete();
        end else begin
            m_rv = 1'b0;
            m_cr = cv;
            if (cv) m_ct = cond_model(code, flags);
            if (ps && pp) begin
                if (m_stack.size() > 0) begin
                    m_rf = m_stack[m_stack.size() - 1];
                    m_stack[m_stack.size() - 1] = flags;
                    m_rv = 1'b1;
                end else begin
                    m_stack.push_back(flags);
                    m_err = 1'b1;
                end
            end else if (ps) begin
                if (m_stack.size() < 4) m_stack.push_back(flags);
                else m_err = 1'b1;
            end else if (pp) begin
                if (m_stack.size() > 0) begin
                    m_rf = m_stack.pop_back();
                    m_rv = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        exp_q.push_back(snapshot());
        tag_q.push_back(tag);

        @(posedge clock);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [4:0] pats [3];
        logic [4:0] ctx  [4];
        pats = '{5'b01000, 5'b10010, 5'b00000};
        ctx  = '{5'b10000, 5'b01000, 5'b00100, 5'b00010};

        // Power-up values before any clock edge.
        #1;
        exp_q.push_back(snapshot());
        tag_q.push_back("powerup");
        checkOutput();

        applyStimulus("reset0", 1, 0, 0, 0, 4'd0, 5'b00000);

        // N=1 Z=0 C=1 V=0: HI, GE, LT.
        applyStimulus("cond_hi", 0, 0, 0, 1, 4'd8,  5'b10100);
        applyStimulus("cond_ge", 0, 0, 0, 1, 4'd10, 5'b10100);
        applyStimulus("cond_lt", 0, 0, 0, 1, 4'd11, 5'b10100);
        applyStimulus("cond_hold", 0, 0, 0, 0, 4'd15, 5'b00000);

        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 16; c++) begin
                applyStimulus($sformatf("cond_p%0d_c%0d", p, c), 0, 0, 0, 1, 4'(c), pats[p]);
            end
        end
        applyStimulus("cond_idle", 0, 0, 0, 0, 4'd0, 5'b11111);

        // Fill to full, then overflow.
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("push%0d", i), 0, 1, 0, 0, 4'd0, ctx[i]);
        end
        applyStimulus("push_over", 0, 1, 0, 0, 4'd0, 5'b11111);

        // Drain in reverse order with single-cycle restore pulses.
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("pop%0d", i), 0, 0, 1, 0, 4'd0, 5'b00000);
            applyStimulus($sformatf("pop%0d_idle", i), 0, 0, 0, 0, 4'd0, 5'b00000);
        end

        // Swap on depth 1.
        applyStimulus("reset1", 1, 0, 0, 0, 4'd0, 5'b00000);
        applyStimulus("push_ones", 0, 1, 0, 0, 4'd0, 5'b11111);
        applyStimulus("swap", 0, 1, 1, 0, 4'd0, 5'b00001);
        applyStimulus("pop_swapped", 0, 0, 1, 0, 4'd0, 5'b10101);

        // Underflow, then reset clears error.
        applyStimulus("pop_empty", 0, 0, 1, 0, 4'd0, 5'b00000);
        applyStimulus("err_sticky", 0, 0, 0, 0, 4'd0, 5'b00000);
        applyStimulus("reset2", 1, 1, 1, 1, 4'd14, 5'b11111);

        // Reset during activity discards the contexts.
        applyStimulus("pushA", 0, 1, 0, 0, 4'd0, 5'b00110);
        applyStimulus("pushB", 0, 1, 0, 0, 4'd0, 5'b11000);
        applyStimulus("reset_pop", 1, 0, 1, 0, 4'd0, 5'b00000);
        applyStimulus("after_reset", 0, 0, 0, 0, 4'd0, 5'b00000);
        applyStimulus("pop_after_reset", 0, 0, 1, 0, 4'd0, 5'b00000);

        // Push and pop together on empty.
        applyStimulus("reset3", 1, 0, 0, 0, 4'd0, 5'b00000);
        applyStimulus("swap_empty", 0, 1, 1, 1, 4'd0, 5'b01011);
        applyStimulus("pop_swap_empty", 0, 0, 1, 0, 4'd0, 5'b00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
